// File: rtl/am2901_useq_if.sv
// Opcode/status bus between the microprogram sequencer and one Am2901 slice.
interface am2901_useq_if;
    logic [8:0] i;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       cin;
    logic       oe;
    logic       cout;
    logic       z;
    logic       ovr;
    logic       f3;

    modport master (
        output i, a, b, d, cin, oe,
        input  cout, z, ovr, f3
    );

    modport slave (
        input  i, a, b, d, cin, oe,
        output cout, z, ovr, f3
    );
endinterface

// File: rtl/am2901_useq.sv
// Microprogram sequencer for one Am2901 slice: fetches a microword at upc,
// pipelines its slice fields, and picks the next address from the live word.
module am2901_useq #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                cp,
    input  logic                rst,
    output logic [ADDR_W-1:0]   upc,
    input  logic [ADDR_W+28:0]  mi_word,
    am2901_useq_if.master       slc,
    output logic                halted,
    output logic                stk_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        SEQ_CONT  = 3'd0,
        SEQ_JMP   = 3'd1,
        SEQ_CJMP  = 3'd2,
        SEQ_CALL  = 3'd3,
        SEQ_RET   = 3'd4,
        SEQ_LDCNT = 3'd5,
        SEQ_LOOP  = 3'd6,
        SEQ_HALT  = 3'd7
    } seq_e;

    // Fields of the word being fetched (they steer the next address).
    logic [ADDR_W-1:0] ba;
    logic              pol;
    logic [1:0]        cc;
    seq_e              seq;

    assign ba  = mi_word[ADDR_W-1:0];
    assign pol = mi_word[ADDR_W+1];
    assign cc  = mi_word[ADDR_W+3:ADDR_W+2];
    assign seq = seq_e'(mi_word[ADDR_W+6:ADDR_W+4]);

    // Pipeline register: only the fields the slice and the flag logic consume
    // are kept; the sequencing fields act on the fetch side.
    logic [8:0] pl_i;
    logic [3:0] pl_a;
    logic [3:0] pl_b;
    logic [3:0] pl_d;
    logic       pl_cin;
    logic       pl_stat;

    logic [3:0]        flg;  // {cout, z, ovr, f3}
    logic [CNT_W-1:0]  cnt;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];

    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] upc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              push;
    logic              pop;
    logic              stk_fault;
    logic              cs_live;
    logic              cs_held;
    logic              cs;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign upc_inc = upc + 1'b1;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - 1'b1);

    assign slc.i   = pl_i;
    assign slc.a   = pl_a;
    assign slc.b   = pl_b;
    assign slc.d   = pl_d;
    assign slc.cin = pl_cin;
    assign slc.oe  = 1'b0;

    assign halted  = (seq == SEQ_HALT);

    // Condition select and next-address / stack / counter decode.
    always_comb begin
        cs_live   = 1'b0;
        cs_held   = 1'b0;
        upc_nxt   = upc_inc;
        cnt_nxt   = cnt;
        push      = 1'b0;
        pop       = 1'b0;
        stk_fault = 1'b0;

        case (cc)
            2'd0:    begin cs_live = slc.z;    cs_held = flg[2]; end
            2'd1:    begin cs_live = slc.cout; cs_held = flg[3]; end
            2'd2:    begin cs_live = slc.ovr;  cs_held = flg[1]; end
            default: begin cs_live = slc.f3;   cs_held = flg[0]; end
        endcase
        // A status-setting word in the pipeline is tested directly so the
        // branch right after it sees its result without a wasted cycle.
        cs = pl_stat ? cs_live : cs_held;

        case (seq)
            SEQ_CONT:  upc_nxt = upc_inc;
            SEQ_JMP:   upc_nxt = ba;
            SEQ_CJMP:  upc_nxt = (cs ^ pol) ? ba : upc_inc;
            SEQ_CALL: begin
                upc_nxt = ba;
                if (sp == SP_W'(STACK_DEPTH)) stk_fault = 1'b1;
                else                          push      = 1'b1;
            end
            SEQ_RET: begin
                if (sp == '0) begin
                    upc_nxt   = '0;
                    stk_fault = 1'b1;
                end else begin
                    upc_nxt = stk[rd_idx];
                    pop     = 1'b1;
                end
            end
            SEQ_LDCNT: cnt_nxt = ba[CNT_W-1:0];
            SEQ_LOOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                    upc_nxt = ba;
                end
            end
            SEQ_HALT:  upc_nxt = upc;
        endcase
    end

    // Sequencer state: address, pipeline, flags, counter, stack pointer, error.
    always_ff @(posedge cp) begin
        if (rst) begin
            upc     <= '0;
            pl_i    <= 9'b001_100_100;
            pl_a    <= '0;
            pl_b    <= '0;
            pl_d    <= '0;
            pl_cin  <= 1'b0;
            pl_stat <= 1'b0;
            flg     <= '0;
            cnt     <= '0;
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            upc     <= upc_nxt;
            pl_i    <= mi_word[ADDR_W+28:ADDR_W+20];
            pl_a    <= mi_word[ADDR_W+19:ADDR_W+16];
            pl_b    <= mi_word[ADDR_W+15:ADDR_W+12];
            pl_d    <= mi_word[ADDR_W+11:ADDR_W+8];
            pl_cin  <= mi_word[ADDR_W+7];
            pl_stat <= mi_word[ADDR_W];
            cnt     <= cnt_nxt;
            if (pl_stat) flg <= {slc.cout, slc.z, slc.ovr, slc.f3};
            if (push)    sp  <= sp + 1'b1;
            if (pop)     sp  <= sp - 1'b1;
            if (stk_fault) stk_err <= 1'b1;
        end
    end

    // Return-address storage; contents are not cleared by reset.
    always_ff @(posedge cp) begin
        if (!rst && push) stk[wr_idx] <= upc_inc;
    end

endmodule
